// File: rtl/sap_pkg.sv
// Shared constants for the SAP control path: opcodes, T-state encodings and
// the bit layout of the packed control word used by the datapath top level.
package sap_pkg;

    // Opcodes (upper nibble of IR)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // One-hot T-states, bit0 = T1
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Control-word bit positions
    localparam int unsigned CW_PC_INC   = 0;
    localparam int unsigned CW_PC_OUT   = 1;
    localparam int unsigned CW_MAR_LOAD = 2;
    localparam int unsigned CW_RAM_OUT  = 3;
    localparam int unsigned CW_IR_LOAD  = 4;
    localparam int unsigned CW_IR_OUT   = 5;
    localparam int unsigned CW_A_LOAD   = 6;
    localparam int unsigned CW_A_OUT    = 7;
    localparam int unsigned CW_B_LOAD   = 8;
    localparam int unsigned CW_ALU_SUB  = 9;
    localparam int unsigned CW_ALU_OUT  = 10;
    localparam int unsigned CW_OUT_LOAD = 11;
    localparam int unsigned CW_W        = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot ring counter. Reset lands on T1; halt_clr empties the ring
// so no T-state (and therefore no control) is active while the machine is halted.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       halt_clr,
    output logic [5:0] ring
);

    logic [5:0] ring_q;

    // Ring register: reset beats halt, halt beats advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= T1;
        end else if (halt_clr) begin
            ring_q <= 6'b000000;
        end else if (advance) begin
            ring_q <= {ring_q[4:0], ring_q[5]};
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: T-state ring plus opcode decode into the per-cycle
// control word, and the machine-wide halted flag.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [5:0]          t_state,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_sub,
    output logic                alu_out,
    output logic                out_load,
    output logic                halted
);

    logic       advance;
    logic       halt_entry;
    logic       halted_q;
    logic [3:0] op;
    logic [5:0] ring;
    ctrl_word_t cw;

    assign advance    = run | step;
    assign op         = opcode[3:0];
    // HLT waits in T4 until the next advancing edge, then freezes the machine.
    assign halt_entry = advance & (ring == T4) & (op == OP_HLT) & ~halted_q;

    sap_ring_counter u_ring (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .halt_clr (halt_entry),
        .ring     (ring)
    );

    // Halted flag: set on HALT entry, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (halt_entry) begin
            halted_q <= 1'b1;
        end
    end

    // Control decode from T-state and opcode; reset and halt force all zero.
    always_comb begin
        cw = '0;
        case (ring)
            T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (op)
                    OP_ADD: begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                        cw[CW_ALU_SUB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (rst || halted_q) begin
            cw = '0;
        end
    end

    assign t_state  = ring;
    assign halted   = halted_q;
    assign pc_inc   = cw[CW_PC_INC];
    assign pc_out   = cw[CW_PC_OUT];
    assign mar_load = cw[CW_MAR_LOAD];
    assign ram_out  = cw[CW_RAM_OUT];
    assign ir_load  = cw[CW_IR_LOAD];
    assign ir_out   = cw[CW_IR_OUT];
    assign a_load   = cw[CW_A_LOAD];
    assign a_out    = cw[CW_A_OUT];
    assign b_load   = cw[CW_B_LOAD];
    assign alu_sub  = cw[CW_ALU_SUB];
    assign alu_out  = cw[CW_ALU_OUT];
    assign out_load = cw[CW_OUT_LOAD];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for the SAP control sequencer.
module tb_sap_control_sequencer;

    // Bench-local control word order:
    // {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
    //  a_load, a_out, b_load, alu_sub, alu_out, out_load}
    localparam logic [11:0] C_NONE     = 12'b0000_0000_0000;
    localparam logic [11:0] C_PC_INC   = 12'b1000_0000_0000;
    localparam logic [11:0] C_PC_OUT   = 12'b0100_0000_0000;
    localparam logic [11:0] C_MAR_LOAD = 12'b0010_0000_0000;
    localparam logic [11:0] C_RAM_OUT  = 12'b0001_0000_0000;
    localparam logic [11:0] C_IR_LOAD  = 12'b0000_1000_0000;
    localparam logic [11:0] C_IR_OUT   = 12'b0000_0100_0000;
    localparam logic [11:0] C_A_LOAD   = 12'b0000_0010_0000;
    localparam logic [11:0] C_A_OUT    = 12'b0000_0001_0000;
    localparam logic [11:0] C_B_LOAD   = 12'b0000_0000_1000;
    localparam logic [11:0] C_ALU_SUB  = 12'b0000_0000_0100;
    localparam logic [11:0] C_ALU_OUT  = 12'b0000_0000_0010;
    localparam logic [11:0] C_OUT_LOAD = 12'b0000_0000_0001;

    localparam logic [11:0] C_FETCH1 = C_PC_OUT | C_MAR_LOAD;
    localparam logic [11:0] C_FETCH3 = C_RAM_OUT | C_IR_LOAD;
    localparam logic [11:0] C_ADDR4  = C_IR_OUT | C_MAR_LOAD;

    logic       clk = 1'b0;
    logic       rst, run, step;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_sub, alu_out, out_load, halted;
    logic [11:0] ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                  a_load, a_out, b_load, alu_sub, alu_out, out_load};

    sap_control_sequencer #(.OPCODE_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .opcode   (opcode),
        .t_state  (t_state),
        .pc_inc   (pc_inc),
        .pc_out   (pc_out),
        .mar_load (mar_load),
        .ram_out  (ram_out),
        .ir_load  (ir_load),
        .ir_out   (ir_out),
        .a_load   (a_load),
        .a_out    (a_out),
        .b_load   (b_load),
        .alu_sub  (alu_sub),
        .alu_out  (alu_out),
        .out_load (out_load),
        .halted   (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // At most one bus driver: pc_out, ram_out, ir_out, a_out, alu_out.
    task automatic check_bus(input string tag);
        int n;
        n = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        check({tag, "_bus"}, 32'(n > 1), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Checks one full instruction starting in T1 with run=1; ends back in T1.
    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [11:0] e4, input logic [11:0] e5,
                             input logic [11:0] e6);
        logic [11:0] exp_cw [6];
        logic [5:0]  exp_t;
        opcode = op;
        run    = 1'b1;
        #1;
        exp_cw[0] = C_FETCH1;
        exp_cw[1] = C_PC_INC;
        exp_cw[2] = C_FETCH3;
        exp_cw[3] = e4;
        exp_cw[4] = e5;
        exp_cw[5] = e6;
        exp_t = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_T%0d_state", name, i + 1), 32'(t_state), 32'(exp_t));
            check($sformatf("%s_T%0d_ctl", name, i + 1), 32'(ctl), 32'(exp_cw[i]));
            check_bus($sformatf("%s_T%0d", name, i + 1));
            tick();
            exp_t = {exp_t[4:0], exp_t[5]};
        end
        check({name, "_wrap_T1"}, 32'(t_state), 32'h01);
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; step = 1'b0; opcode = 4'b0000;

        // Reset held for two cycles with run high
        tick();
        tick();
        check("rst_state", 32'(t_state), 32'h01);
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ctl", 32'(ctl), 32'(C_FETCH1));

        run_instr("lda", 4'b0000, C_ADDR4, C_RAM_OUT | C_B_LOAD ^ C_B_LOAD | C_A_LOAD, C_NONE);
        run_instr("add", 4'b0001, C_ADDR4, C_RAM_OUT | C_B_LOAD, C_ALU_OUT | C_A_LOAD);
        run_instr("sub", 4'b0010, C_ADDR4, C_RAM_OUT | C_B_LOAD,
                  C_ALU_OUT | C_A_LOAD | C_ALU_SUB);
        run_instr("out", 4'b1110, C_A_OUT | C_OUT_LOAD, C_NONE, C_NONE);
        run_instr("nop5", 4'b0101, C_NONE, C_NONE, C_NONE);

        // Single-step mode: advance to T2, then hold for 10 cycles
        opcode = 4'b0000;
        tick();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold%0d_state", i), 32'(t_state), 32'h02);
            check($sformatf("hold%0d_ctl", i), 32'(ctl), 32'(C_PC_INC));
        end
        step = 1'b1; tick(); step = 1'b0;
        check("step_T3", 32'(t_state), 32'h04);
        tick();
        check("step_T3_hold", 32'(t_state), 32'h04);
        step = 1'b1; tick(); step = 1'b0;
        check("step_T4", 32'(t_state), 32'h08);
        check("step_T4_ctl", 32'(ctl), 32'(C_ADDR4));
        step = 1'b1; tick(); step = 1'b0;
        check("step_T5", 32'(t_state), 32'h10);
        rst = 1'b1;
        #1;
        check("rst_T5_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        rst = 1'b0;
        #1;
        check("rst_T5_state", 32'(t_state), 32'h01);
        check("rst_T5_fetch", 32'(ctl), 32'(C_FETCH1));

        // HLT: run through fetch into T4, then halt on the next edge
        opcode = 4'b1111;
        run = 1'b1;
        #1;
        check("hlt_T1", 32'(ctl), 32'(C_FETCH1));
        tick(); tick(); tick();
        check("hlt_T4_state", 32'(t_state), 32'h08);
        check("hlt_T4_ctl", 32'(ctl), 32'(C_NONE));
        check("hlt_T4_halted", 32'(halted), 32'd0);
        tick();
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_state", 32'(t_state), 32'h00);
        for (int i = 0; i < 20; i++) begin
            run  = (i % 3) != 0;
            step = (i % 2) == 0;
            tick();
            check($sformatf("halt%0d_halted", i), 32'(halted), 32'd1);
            check($sformatf("halt%0d_state", i), 32'(t_state), 32'h00);
            check($sformatf("halt%0d_ctl", i), 32'(ctl), 32'(C_NONE));
        end
        step = 1'b0;
        run  = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("unhalt_state", 32'(t_state), 32'h01);
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_ctl", 32'(ctl), 32'(C_FETCH1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Control sequencer for the SAP computer. It runs a six-state one-hot ring counter (T1–T6) and decodes the current T-state plus the instruction-register opcode into the per-cycle control word. The control word drives the PC, MAR, RAM, IR, A/B registers, ALU and output register. The block sits between the instruction register and every bus-attached datapath register, and it owns the halt condition for the whole machine.

## Interface
Parameters:
- OPCODE_W, 4, opcode width (upper nibble of IR); only 4 is supported.

Ports:
- clk  in  1  single system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  free-run enable; when high, advance one T-state per cycle
- step  in  1  single-step request; when run=0, advance one T-state on each cycle step=1 (externally debounced and one-cycle pulsed)
- opcode  in  OPCODE_W  IR upper nibble; valid from T4
- t_state  out  6  one-hot T1..T6 (bit0=T1); 0 when halted
- pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out  out  1 each  datapath controls, active-high
- a_load, a_out, b_load, alu_sub, alu_out, out_load  out  1 each  datapath controls, active-high
- halted  out  1  machine halted (registered)

## Operation
- advance = run | step. Without advance, state holds and the outputs stay stable.
- Ring: T1→T2→…→T6→T1 on each advancing edge.
- Fetch, all opcodes:
  - T1: pc_out, mar_load
  - T2: pc_inc
  - T3: ram_out, ir_load
- Execute, keyed on opcode:
  - LDA 0000: T4 ir_out+mar_load; T5 ram_out+a_load; T6 none.
  - ADD 0001: T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load.
  - SUB 0010: same as ADD, plus alu_sub in T6 only.
  - OUT 1110: T4 a_out+out_load; T5, T6 none.
  - HLT 1111: T4 none. The next advancing edge enters HALT: t_state=0, halted=1, all controls 0. HALT ignores run/step and is left only by rst.
  - All other opcodes: NOP, with no controls in T4–T6.
- Controls are combinational decodes of registered state and opcode. At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is active in any state.
- rst=1 forces all controls to 0 combinationally in the same cycle. On that edge the state goes to T1 with halted=0. rst takes priority over advance and over HALT entry.

## Timing
- Reset values: t_state=000001, halted=0, all controls 0 while rst is high. After release, the first cycle presents T1 controls.
- One instruction = 6 advancing cycles; 6 clocks at run=1.
- Each control is valid for the whole cycle of its T-state. Datapath loads capture on the edge that leaves that T-state.
- opcode is sampled combinationally in T4–T6. It must be stable from the T3→T4 edge, which holds because IR loads on that edge.
- Halt latency: halted rises on the first advancing edge after entering T4 with opcode=1111.
- step with run=1: no extra effect (advance is already 1).
- rst mid-instruction, any T-state: T1 on the next cycle. No partial control survives.

## Structure
- Package sap_pkg holds:
  - opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - T-state one-hot constants: T1..T6
  - control-word bit index localparams and a packed control-word width, shared with the datapath top level
- Sub-module sap_ring_counter: 6-bit one-hot ring with synchronous reset to T1, advance enable, and a halt-clear input that zeroes the ring.
- Top-level contents: decode logic and the halted register.

## Test plan
- Reset: rst=1 for 2 cycles with run=1 → t_state=000001, all controls 0, halted=0. First post-reset cycle → pc_out=mar_load=1 only.
- LDA (opcode=0000), run=1:
  - T1 pc_out+mar_load
  - T2 pc_inc
  - T3 ram_out+ir_load
  - T4 ir_out+mar_load
  - T5 ram_out+a_load
  - T6 none
  - back to T1 on the 7th cycle
- ADD (0001) vs SUB (0010): T5 ram_out+b_load, T6 alu_out+a_load for both. alu_sub=1 only in the SUB T6 and 0 in every other cycle.
- OUT (1110) → T4 a_out+out_load, T5/T6 all 0. Opcode 0101 → T4–T6 all 0. Check no two bus drivers are ever high together.
- HLT (1111), run=1 → after the T4 edge: halted=1, t_state=0, controls 0 for 20 further cycles, including step pulses. rst=1 → T1, halted=0.
- run=0:
  - no step for 10 cycles → state holds at T2
  - three single-cycle step pulses → T3, T4, T5
  - rst asserted in T5 → T1 on the next cycle
